fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the program counter (PC), drives the word-indexed

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction memory and
// captures the returned word into the IF/ID register. Handles stall, redirect, HALT and faults.
module fetch_unit #(
  parameter int unsigned          BITS_SIZE   = 32,
  parameter int unsigned          MEMORY_SIZE = 256,
  parameter int unsigned          RESET_PC    = 0,
  parameter logic [BITS_SIZE-1:0] HALT_WORD   = {BITS_SIZE{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [BITS_SIZE-1:0] redirect_pc,
  output logic [BITS_SIZE-1:0] instr_addr,
  input  logic [BITS_SIZE-1:0] instr_data,
  output logic [BITS_SIZE-1:0] if_id_instr,
  output logic [BITS_SIZE-1:0] if_id_pc,
  output logic [BITS_SIZE-1:0] if_id_pc_plus1,
  output logic                 if_id_valid,
  output logic                 fetch_fault,
  output logic                 halted
);

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  localparam logic [BITS_SIZE-1:0] MemWords = BITS_SIZE'(MEMORY_SIZE);
  localparam logic [BITS_SIZE-1:0] ResetPc  = BITS_SIZE'(RESET_PC);
  localparam logic [BITS_SIZE-1:0] One      = BITS_SIZE'(1);

  state_e               state_q;
  logic [BITS_SIZE-1:0] pc_q;
  logic [BITS_SIZE-1:0] instr_q;
  logic [BITS_SIZE-1:0] id_pc_q;
  logic [BITS_SIZE-1:0] id_pc_plus1_q;
  logic                 valid_q;
  logic                 fault_q;
  logic                 halted_q;

  logic                 pc_in_range;
  logic [BITS_SIZE-1:0] pc_next_seq;

  assign pc_in_range = (pc_q < MemWords);
  assign pc_next_seq = pc_q + One;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      pc_q          <= ResetPc;
      instr_q       <= '0;
      id_pc_q       <= '0;
      id_pc_plus1_q <= '0;
      valid_q       <= 1'b0;
      fault_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else if (redirect) begin
      // Word at the current PC is wrong-path: drop it and restart at the target.
      state_q       <= StRun;
      pc_q          <= redirect_pc;
      instr_q       <= '0;
      id_pc_q       <= '0;
      id_pc_plus1_q <= '0;
      valid_q       <= 1'b0;
      fault_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        StRun: begin
          if (pc_in_range) begin
            instr_q       <= instr_data;
            id_pc_q       <= pc_q;
            id_pc_plus1_q <= pc_next_seq;
            valid_q       <= 1'b1;
            pc_q          <= pc_next_seq;
            if (instr_data == HALT_WORD) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end
          end else begin
            instr_q       <= '0;
            id_pc_q       <= '0;
            id_pc_plus1_q <= '0;
            valid_q       <= 1'b0;
            state_q       <= StFault;
            fault_q       <= 1'b1;
          end
        end
        StHalt, StFault: begin
          instr_q       <= '0;
          id_pc_q       <= '0;
          id_pc_plus1_q <= '0;
          valid_q       <= 1'b0;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign instr_addr     = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus1 = id_pc_plus1_q;
  assign if_id_valid    = valid_q;
  assign fetch_fault    = fault_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random stall/redirect/reset
// traffic, all checked against a cycle-level reference model of the fetch rules.
module tb_fetch_unit;

  localparam int unsigned    W     = 32;
  localparam int unsigned    MSIZE = 256;
  localparam logic [W-1:0]   HALTW = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic [W-1:0] instr_addr;
  logic [W-1:0] instr_data;
  logic [W-1:0] if_id_instr;
  logic [W-1:0] if_id_pc;
  logic [W-1:0] if_id_pc_plus1;
  logic         if_id_valid;
  logic         fetch_fault;
  logic         halted;

  logic [W-1:0] mem [0:511];

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [W-1:0] m_pc, m_instr, m_ipc, m_ipc1;
  logic         m_valid, m_fault, m_halted;

  fetch_unit #(
    .BITS_SIZE  (W),
    .MEMORY_SIZE(MSIZE),
    .RESET_PC   (0),
    .HALT_WORD  (HALTW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .instr_addr    (instr_addr),
    .instr_data    (instr_data),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus1(if_id_pc_plus1),
    .if_id_valid   (if_id_valid),
    .fetch_fault   (fetch_fault),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mem_read(input logic [W-1:0] a);
    return (a < 512) ? mem[a[8:0]] : 32'hDEAD_BEEF;
  endfunction

  assign instr_data = mem_read(instr_addr);

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_bubble();
    m_instr = '0; m_ipc = '0; m_ipc1 = '0; m_valid = 1'b0;
  endtask

  // One clock of the fetch rules, evaluated with the inputs present before the edge.
  task automatic model_step();
    logic [W-1:0] word;
    if (reset) begin
      m_pc = '0; model_bubble(); m_fault = 1'b0; m_halted = 1'b0;
    end else if (redirect) begin
      m_pc = redirect_pc; model_bubble(); m_fault = 1'b0; m_halted = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (m_halted || m_fault) begin
      model_bubble();
    end else if (m_pc < MSIZE) begin
      word    = mem_read(m_pc);
      m_instr = word;
      m_ipc   = m_pc;
      m_ipc1  = m_pc + 1;
      m_valid = 1'b1;
      m_pc    = m_pc + 1;
      if (word == HALTW) m_halted = 1'b1;
    end else begin
      model_bubble();
      m_fault = 1'b1;
    end
  endtask

  task automatic compare_all();
    check_eq("instr_addr", instr_addr, m_pc);
    check_eq("if_id_instr", if_id_instr, m_instr);
    check_eq("if_id_pc", if_id_pc, m_ipc);
    check_eq("if_id_pc_plus1", if_id_pc_plus1, m_ipc1);
    check_eq("if_id_valid", W'(if_id_valid), W'(m_valid));
    check_eq("fetch_fault", W'(fetch_fault), W'(m_fault));
    check_eq("halted", W'(halted), W'(m_halted));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [W-1:0] rpc);
    reset = r; stall = s; redirect = rd; redirect_pc = rpc;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000 + i;
    mem[0] = 11; mem[1] = 22; mem[2] = 33; mem[3] = 44;
    mem[4] = 55; mem[5] = HALTW;
    m_pc = 'x; m_instr = 'x; m_ipc = 'x; m_ipc1 = 'x;
    m_valid = 1'bx; m_fault = 1'bx; m_halted = 1'bx;

    drive(1, 0, 0, 0);
    @(negedge clk);
    step();
    step();
    check_eq("reset_addr", instr_addr, 0);
    check_eq("reset_valid", W'(if_id_valid), 0);

    // Sequential fetch with latency 1.
    drive(0, 0, 0, 0);
    step();
    check_eq("t1_instr0", if_id_instr, 11);
    check_eq("t1_pc1", if_id_pc_plus1, 1);
    step();
    check_eq("t1_instr1", if_id_instr, 22);
    check_eq("t1_addr2", instr_addr, 2);

    // Stall holds PC and IF/ID.
    drive(0, 1, 0, 0);
    step();
    step();
    check_eq("t2_hold_instr", if_id_instr, 22);
    check_eq("t2_hold_addr", instr_addr, 2);
    drive(0, 0, 0, 0);
    step();
    check_eq("t2_release", if_id_instr, 33);

    // Redirect to 0x10.
    drive(0, 0, 1, 32'h10);
    step();
    check_eq("t3_bubble", W'(if_id_valid), 0);
    check_eq("t3_addr", instr_addr, 32'h10);
    drive(0, 0, 0, 0);
    step();
    check_eq("t3_pc", if_id_pc, 32'h10);

    // Redirect beats stall.
    drive(0, 1, 1, 32'h20);
    step();
    check_eq("t4_addr", instr_addr, 32'h20);

    // Last legal word then fault.
    drive(0, 0, 1, 32'hFF);
    step();
    drive(0, 0, 0, 0);
    step();
    check_eq("t5_last_pc", if_id_pc, 32'hFF);
    check_eq("t5_addr", instr_addr, 32'h100);
    step();
    check_eq("t5_fault", W'(fetch_fault), 1);
    step();
    step();
    drive(0, 0, 1, 0);
    step();
    check_eq("t5_clear", W'(fetch_fault), 0);

    // HALT word.
    drive(0, 0, 1, 4);
    step();
    drive(0, 0, 0, 0);
    step();
    step();
    check_eq("t6_halt_instr", if_id_instr, HALTW);
    check_eq("t6_halted", W'(halted), 1);
    step();
    step();
    check_eq("t6_hold_addr", instr_addr, 6);
    drive(1, 0, 0, 0);
    step();
    check_eq("t6_reset_halt", W'(halted), 0);

    // Random traffic.
    for (int i = 0; i < 512; i++) mem[i] = ($urandom_range(0, 63) == 0) ? HALTW : $urandom;
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      stall       = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 19))
        0:       redirect_pc = 32'hFFFF_FFFF;
        1, 2:    redirect_pc = $urandom_range(250, 300);
        default: redirect_pc = $urandom_range(0, 255);
      endcase
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
